// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared defaults and FSM encoding for the RO response collector
package ro_puf_pkg;

    localparam int DEF_CHAL_W     = 2;
    localparam int DEF_RESP_BITS  = 8;
    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_VOTES      = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETTLE = 3'd1;
    localparam state_t ST_SAMPLE = 3'd2;
    localparam state_t ST_SHIFT  = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/majority_sampler.sv
// rtl/majority_sampler.sv - counts ones in Q over a vote window and registers the majority decision
module majority_sampler #(
    parameter int VOTES = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic                         q_in,
    output logic [$clog2(VOTES+1)-1:0]   ones,
    output logic                         decision
);

    localparam int CW = $clog2(VOTES + 1);
    localparam logic [CW-1:0] HALF = CW'(VOTES / 2);

    logic [CW-1:0] ones_next;

    assign ones_next = ones + CW'(q_in);

    // Accumulate ones while enabled; decision tracks the running majority so it is final after the last vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones     <= '0;
            decision <= 1'b0;
        end else if (clr) begin
            ones     <= '0;
            decision <= 1'b0;
        end else if (en) begin
            ones     <= ones_next;
            decision <= (ones_next > HALF);
        end
    end

endmodule

// File: rtl/ro_response_collector.sv
// rtl/ro_response_collector.sv - RO challenge sequencer, Q majority vote and response word builder
module ro_response_collector
    import ro_puf_pkg::*;
#(
    parameter int CHAL_W     = DEF_CHAL_W,
    parameter int RESP_BITS  = DEF_RESP_BITS,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int VOTES      = DEF_VOTES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic [CHAL_W-1:0]    chal_base,
    input  logic                 q_in,
    output logic [CHAL_W-1:0]    check_out,
    output logic                 busy,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] resp_data
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int VW = $clog2(VOTES + 1);
    localparam int BW = $clog2(RESP_BITS);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [VW-1:0] VOTE_LAST   = VW'(VOTES - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_BITS - 1);

    state_t            state;
    logic [CHAL_W-1:0] chal_idx;
    logic [SW-1:0]     settle_cnt;
    logic [VW-1:0]     vote_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              sampler_clr;
    logic              sampler_en;
    logic              vote_bit;
    logic [VW-1:0]     ones_unused;

    // The sampler is held clear outside a vote window so each bit starts from zero ones
    assign sampler_clr = clear || (state == ST_IDLE) || (state == ST_SHIFT);
    assign sampler_en  = (state == ST_SAMPLE);
    assign busy        = (state != ST_IDLE);
    assign resp_valid  = (state == ST_DONE);

    majority_sampler #(
        .VOTES(VOTES)
    ) u_sampler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sampler_clr),
        .en       (sampler_en),
        .q_in     (q_in),
        .ones     (ones_unused),
        .decision (vote_bit)
    );

    // Word sequencer: settle on a challenge, vote on Q, shift the decided bit, repeat per bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            chal_idx   <= '0;
            check_out  <= '0;
            settle_cnt <= '0;
            vote_cnt   <= '0;
            bit_cnt    <= '0;
            resp_data  <= '0;
        end else if (clear) begin
            state      <= ST_IDLE;
            chal_idx   <= '0;
            settle_cnt <= '0;
            vote_cnt   <= '0;
            bit_cnt    <= '0;
            resp_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        chal_idx   <= chal_base;
                        check_out  <= chal_base;
                        settle_cnt <= '0;
                        vote_cnt   <= '0;
                        bit_cnt    <= '0;
                        resp_data  <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (vote_cnt == VOTE_LAST) begin
                        vote_cnt <= '0;
                        state    <= ST_SHIFT;
                    end else begin
                        vote_cnt <= vote_cnt + VW'(1);
                    end
                end
                ST_SHIFT: begin
                    resp_data <= {resp_data[RESP_BITS-2:0], vote_bit};
                    chal_idx  <= chal_idx + CHAL_W'(1);
                    check_out <= chal_idx + CHAL_W'(1);
                    bit_cnt   <= bit_cnt + BW'(1);
                    state     <= (bit_cnt == BIT_LAST) ? ST_DONE : ST_SETTLE;
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_response_collector.sv
// tb/tb_ro_response_collector.sv - self-checking bench for ro_response_collector
module tb_ro_response_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       clear;
    logic [1:0] chal_base;
    logic       q_in;
    logic [1:0] check_out;
    logic       busy;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ro_response_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clear      (clear),
        .chal_base  (chal_base),
        .q_in       (q_in),
        .check_out  (check_out),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    // Q value for the edge that is edge_n clocks after the start edge; noise outside vote windows
    function automatic logic q_for_edge(input logic [7:0] word, input int edge_n, input bit noisy);
        int   b;
        int   r;
        logic bv;
        b = edge_n / 20;
        r = edge_n % 20;
        if (b < 8 && r >= 17) begin
            bv = word[7 - b];
            if (noisy && r == 18) return ~bv;
            return bv;
        end
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_word(input logic [1:0] base, input logic [7:0] word, input bit noisy, input int hold);
        int         lat;
        int         co_bad;
        int         busy_bad;
        int         st_bad;
        int         xfers;
        logic [7:0] first;
        logic [7:0] exp_w;
        exp_q.push_back(word);
        @(negedge clk);
        chal_base = base;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        chal_base = ~base;
        lat = -1; co_bad = 0; busy_bad = 0;
        for (int n = 0; n <= 200; n++) begin
            if (resp_valid === 1'b1) begin
                lat = n;
                break;
            end
            if (check_out !== 2'(int'(base) + n / 20)) co_bad++;
            if (busy !== 1'b1) busy_bad++;
            q_in = q_for_edge(word, n + 1, noisy);
            @(negedge clk);
        end
        tests++;
        if (lat !== 160) begin
            fails++;
            $display("FAIL latency: got %0d cycles, expected 160", lat);
        end
        tests++;
        if (co_bad !== 0) begin
            fails++;
            $display("FAIL check_out_seq: %0d wrong cycles, expected 0 (base %0d)", co_bad, base);
        end
        tests++;
        if (busy_bad !== 0) begin
            fails++;
            $display("FAIL busy_during_word: %0d low cycles, expected 0", busy_bad);
        end
        if (lat < 0) begin
            exp_w = exp_q.pop_front();
            return;
        end
        first  = resp_data;
        st_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_data !== first) st_bad++;
        end
        if (hold > 0) begin
            tests++;
            if (st_bad !== 0) begin
                fails++;
                $display("FAIL backpressure_stable: %0d unstable cycles, expected 0", st_bad);
            end
        end
        resp_ready = 1'b1;
        exp_w = exp_q.pop_front();
        tests++;
        if (resp_data !== exp_w) begin
            fails++;
            $display("FAIL resp_data: got %h, expected %h", resp_data, exp_w);
        end
        @(negedge clk);
        tests++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL valid_after_xfer: valid=%b busy=%b, expected 0 0", resp_valid, busy);
        end
        xfers = 0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid === 1'b1) xfers++;
            @(negedge clk);
        end
        resp_ready = 1'b0;
        tests++;
        if (xfers !== 0 || resp_data !== exp_w) begin
            fails++;
            $display("FAIL single_xfer: extra valid=%0d data=%h, expected 0 and %h", xfers, resp_data, exp_w);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; chal_base = 2'd3; q_in = 1'b1; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        tests++;
        if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, expected 0", resp_valid); end
        tests++;
        if (resp_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h, expected 00", resp_data); end
        tests++;
        if (check_out !== 2'd0) begin fails++; $display("FAIL reset_check_out: got %0d, expected 0", check_out); end
    endtask

    task automatic test_timing();
        run_word(2'd2, 8'hFF, 1'b0, 0);
    endtask

    task automatic test_majority();
        run_word(2'd0, 8'hAA, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        run_word(2'd1, 8'h5C, 1'b1, 50);
    endtask

    task automatic test_abort();
        int co_bad;
        @(negedge clk);
        chal_base = 2'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        q_in  = 1'b1;
        co_bad = 0;
        for (int n = 0; n < 70; n++) begin
            if (check_out !== 2'(n / 20) || busy !== 1'b1) co_bad++;
            start     = (n == 30);
            chal_base = (n == 30) ? 2'd3 : 2'd0;
            if (n == 69) begin
                tests++;
                if (resp_data !== 8'h07) begin
                    fails++;
                    $display("FAIL abort_partial_word: got %h, expected 07", resp_data);
                end
                clear = 1'b1;
            end
            @(negedge clk);
        end
        clear = 1'b0;
        tests++;
        if (co_bad !== 0) begin fails++; $display("FAIL abort_start_ignored: %0d bad cycles, expected 0", co_bad); end
        tests++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 8'h00) begin
            fails++;
            $display("FAIL abort_clear: busy=%b valid=%b data=%h, expected 0 0 00", busy, resp_valid, resp_data);
        end
        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL start_with_clear: busy=%b, expected 0", busy); end
        run_word(2'd3, 8'hFF, 1'b0, 0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        chal_base = 2'd2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        q_in  = 1'b1;
        repeat (97) @(negedge clk);
        tests++;
        if (resp_data !== 8'h0F || check_out !== 2'd2) begin
            fails++;
            $display("FAIL pre_reset_state: data=%h check_out=%0d, expected 0F 2", resp_data, check_out);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 8'h00 || check_out !== 2'd0) begin
            fails++;
            $display("FAIL async_reset: busy=%b valid=%b data=%h co=%0d, expected all 0", busy, resp_valid, resp_data, check_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_word(2'd1, 8'h3C, 1'b1, 3);
    endtask

    initial begin
        test_reset();
        test_timing();
        test_majority();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
